countdown_timer: RTL and testbench

- Counterpart of the team's up-counting stopwatch: loads an hh:mm:ss preset and counts down to 00:00:00 at one step per prescaled tick, then raises ring.
- Uses the same sec/min/hour field widths as the stopwatch so both blocks share display and recording logic.
- Sits beside the stopwatch under the same clk/reset domain.

---
 rtl/countdown_timer.sv | 197 +++++++++++++++++++
 tb/tb_countdown_timer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loads an hh:mm:ss preset, counts down one step per prescaled tick, rings at 00:00:00.
// Latency: every control strobe takes effect on the next rising clk edge; all outputs are registered.
// Backpressure: none; strobes are sampled every cycle and ignored in states where they do not apply.
module countdown_timer #(
    parameter int TICK_DIV = 1,
    parameter int MAX_HOUR = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] load_sec,
    input  logic [6:0] load_min,
    input  logic [4:0] load_hour,
    input  logic       start,
    input  logic       pause,
    input  logic       clear_ring,
    output logic [6:0] sec,
    output logic [6:0] min,
    output logic [4:0] hour,
    output logic       running,
    output logic       ring,
    output logic       done,
    output logic       load_err
);

    // Prescaler is wide enough to hold TICK_DIV-1 even when TICK_DIV is a power of two.
    localparam int              PW         = $clog2(TICK_DIV) + 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
    localparam logic [4:0]      HOUR_LIMIT = 5'(MAX_HOUR);
    localparam logic [6:0]      SIXTY_M1   = 7'd59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    sec_q, sec_d;
    logic [6:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          ring_q, ring_d;
    logic          done_q, done_d;
    logic          load_err_q, load_err_d;

    // Decoded control intent for this cycle.
    logic preset_ok;
    logic value_zero;
    logic last_step;
    logic tick;
    logic expire;
    logic clear_act;
    logic load_act;
    logic load_ok;
    logic load_bad;
    logic pause_act;
    logic start_act;

    // Decode strobes against the current state, applying clear_ring > load > pause > start.
    always_comb begin
        preset_ok  = (load_sec <= SIXTY_M1) && (load_min <= SIXTY_M1) && (load_hour <= HOUR_LIMIT);
        value_zero = (sec_q == 7'd0) && (min_q == 7'd0) && (hour_q == 5'd0);
        last_step  = (sec_q == 7'd1) && (min_q == 7'd0) && (hour_q == 5'd0);
        tick       = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
        // The expiring tick beats a same-cycle pause.
        expire     = tick && last_step;
        clear_act  = (state_q == ST_EXPIRED) && clear_ring;
        // Load is ignored while running, and a clear in EXPIRED pre-empts it.
        load_act   = load && (state_q != ST_RUN) && !clear_act;
        load_ok    = load_act && preset_ok;
        load_bad   = load_act && !preset_ok;
        pause_act  = pause && (state_q == ST_RUN) && !expire;
        // A rejected load still claims the cycle, so start never slips past it.
        start_act  = start && ((state_q == ST_IDLE) || (state_q == ST_PAUSED))
                     && !value_zero && !load_act;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load_ok) begin
                    state_d = ST_IDLE;
                end else if (start_act) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (expire) begin
                    state_d = ST_EXPIRED;
                end else if (pause_act) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (load_ok) begin
                    state_d = ST_IDLE;
                end else if (start_act) begin
                    state_d = ST_RUN;
                end
            end
            ST_EXPIRED: begin
                if (clear_act || load_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every flag lands on the same edge as the transition.
    always_comb begin
        running_d  = (state_d == ST_RUN);
        ring_d     = (state_d == ST_EXPIRED);
        done_d     = expire;
        load_err_d = load_bad;
    end

    // Time fields and prescaler: preset on legal load, borrow-decrement on tick, hold otherwise.
    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        presc_d = presc_q;
        if (load_ok) begin
            sec_d   = load_sec;
            min_d   = load_min;
            hour_d  = load_hour;
            presc_d = '0;
        end else if ((state_q == ST_RUN) && !pause_act) begin
            if (tick) begin
                presc_d = '0;
                if (sec_q != 7'd0) begin
                    sec_d = sec_q - 7'd1;
                end else if (min_q != 7'd0) begin
                    min_d = min_q - 7'd1;
                    sec_d = SIXTY_M1;
                end else if (hour_q != 5'd0) begin
                    hour_d = hour_q - 5'd1;
                    min_d  = SIXTY_M1;
                    sec_d  = SIXTY_M1;
                end
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end else if (start_act && (state_q == ST_IDLE)) begin
            // A fresh run starts a full tick period; resume from PAUSED keeps the partial count.
            presc_d = '0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            presc_q    <= '0;
            running_q  <= 1'b0;
            ring_q     <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            presc_q    <= presc_d;
            running_q  <= running_d;
            ring_q     <= ring_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign sec      = sec_q;
    assign min      = min_q;
    assign hour     = hour_q;
    assign running  = running_q;
    assign ring     = ring_q;
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance at TICK_DIV=1, one at TICK_DIV=4, shared stimulus.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
// Each check goes through chk(), which counts comparisons and reports mismatches.
module tb_countdown_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [6:0] load_sec;
    logic [6:0] load_min;
    logic [4:0] load_hour;
    logic       start;
    logic       pause;
    logic       clear_ring;

    logic [6:0] sec1, min1;
    logic [4:0] hour1;
    logic       running1, ring1, done1, load_err1;
    logic [6:0] sec4, min4;
    logic [4:0] hour4;
    logic       running4, ring4, done4, load_err4;

    int total;
    int bad;
    int ndone;

    countdown_timer #(.TICK_DIV(1), .MAX_HOUR(12)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_sec   (load_sec),
        .load_min   (load_min),
        .load_hour  (load_hour),
        .start      (start),
        .pause      (pause),
        .clear_ring (clear_ring),
        .sec        (sec1),
        .min        (min1),
        .hour       (hour1),
        .running    (running1),
        .ring       (ring1),
        .done       (done1),
        .load_err   (load_err1)
    );

    countdown_timer #(.TICK_DIV(4), .MAX_HOUR(12)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_sec   (load_sec),
        .load_min   (load_min),
        .load_hour  (load_hour),
        .start      (start),
        .pause      (pause),
        .clear_ring (clear_ring),
        .sec        (sec4),
        .min        (min4),
        .hour       (hour4),
        .running    (running4),
        .ring       (ring4),
        .done       (done4),
        .load_err   (load_err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic ld(input logic [4:0] h, input logic [6:0] m, input logic [6:0] s);
        load_hour = h;
        load_min  = m;
        load_sec  = s;
        load      = 1'b1;
        cyc();
        load      = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        load = 1'b0; load_sec = '0; load_min = '0; load_hour = '0;
        start = 1'b0; pause = 1'b0; clear_ring = 1'b0;

        // Reset values, observed asynchronously before any clock edge.
        reset = 1'b1;
        #2;
        chk("rst_sec", sec1, 0);
        chk("rst_min", min1, 0);
        chk("rst_hour", hour1, 0);
        chk("rst_running", running1, 0);
        chk("rst_ring", ring1, 0);
        chk("rst_done", done1, 0);
        chk("rst_load_err", load_err1, 0);
        cyc();
        reset = 1'b0;

        // Short countdown at TICK_DIV=1.
        ld(5'd0, 7'd0, 7'd3);
        chk("ld3_sec", sec1, 3);
        chk("ld3_err", load_err1, 0);
        pulse_start();
        chk("run_rise", running1, 1);
        chk("run_sec3", sec1, 3);
        cyc();
        chk("run_sec2", sec1, 2);
        cyc();
        chk("run_sec1", sec1, 1);
        chk("run_ring_pre", ring1, 0);
        cyc();
        chk("exp_sec0", sec1, 0);
        chk("exp_done", done1, 1);
        chk("exp_ring", ring1, 1);
        chk("exp_running", running1, 0);
        cyc();
        chk("exp_done_drop", done1, 0);
        chk("exp_ring_hold", ring1, 1);
        chk("exp_sec_hold", sec1, 0);

        // clear_ring together with start in EXPIRED: back to IDLE, start dropped.
        clear_ring = 1'b1;
        start      = 1'b1;
        cyc();
        clear_ring = 1'b0;
        start      = 1'b0;
        chk("clr_ring", ring1, 0);
        chk("clr_running", running1, 0);
        cyc();
        chk("clr_running2", running1, 0);

        // Zero preset cannot start.
        ld(5'd0, 7'd0, 7'd0);
        pulse_start();
        chk("zero_start", running1, 0);
        cyc();
        chk("zero_start2", running1, 0);

        // Illegal presets leave fields untouched and pulse load_err for one cycle.
        ld(5'd0, 7'd0, 7'd5);
        chk("legal_sec5", sec1, 5);
        ld(5'd0, 7'd5, 7'd60);
        chk("bad_sec_err", load_err1, 1);
        chk("bad_sec_keep_sec", sec1, 5);
        chk("bad_sec_keep_min", min1, 0);
        cyc();
        chk("bad_sec_err_drop", load_err1, 0);
        ld(5'd13, 7'd0, 7'd0);
        chk("bad_hour_err", load_err1, 1);
        chk("bad_hour_keep", hour1, 0);
        chk("bad_hour_keep_sec", sec1, 5);

        // One hour at TICK_DIV=1: 3600 ticks, borrow across all fields, a single done.
        do_reset();
        ld(5'd1, 7'd0, 7'd0);
        pulse_start();
        chk("hr_running", running1, 1);
        chk("hr_hour", hour1, 1);
        cyc();
        chk("hr_b_hour", hour1, 0);
        chk("hr_b_min", min1, 59);
        chk("hr_b_sec", sec1, 59);
        ndone = 0;
        for (int i = 0; i < 3599; i++) begin
            cyc();
            if (done1) ndone++;
            if (i == 0) chk("hr_second_tick", sec1, 58);
            if (i == 3597) chk("hr_ring_early", ring1, 0);
        end
        chk("hr_end_sec", sec1, 0);
        chk("hr_end_min", min1, 0);
        chk("hr_end_hour", hour1, 0);
        chk("hr_end_ring", ring1, 1);
        chk("hr_end_done", done1, 1);
        cyc();
        if (done1) ndone++;
        chk("hr_done_count", ndone, 1);
        chk("hr_sec_no_underflow", sec1, 0);

        // Pause/resume at TICK_DIV=4 keeps the partial prescaler count.
        do_reset();
        ld(5'd0, 7'd0, 7'd10);
        pulse_start();
        chk("p4_running", running4, 1);
        cyc();
        cyc();
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        chk("p4_paused", running4, 0);
        chk("p4_sec_paused", sec4, 10);
        for (int i = 0; i < 10; i++) cyc();
        chk("p4_sec_hold", sec4, 10);
        chk("p4_still_paused", running4, 0);
        pulse_start();
        chk("p4_resumed", running4, 1);
        chk("p4_sec_r0", sec4, 10);
        cyc();
        chk("p4_sec_r1", sec4, 10);
        cyc();
        chk("p4_sec_r2", sec4, 9);

        // Load ignored in RUN, then async reset mid-countdown at 00:02:17.
        do_reset();
        ld(5'd0, 7'd2, 7'd17);
        pulse_start();
        chk("ar_start_sec", sec1, 17);
        load_hour = 5'd0; load_min = 7'd0; load_sec = 7'd5;
        load = 1'b1;
        cyc();
        load = 1'b0;
        chk("ar_ld_ignored_sec", sec1, 16);
        chk("ar_ld_ignored_min", min1, 2);
        chk("ar_ld_no_err", load_err1, 0);
        chk("ar_still_running", running1, 1);
        cyc();
        chk("ar_sec15", sec1, 15);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_sec", sec1, 0);
        chk("ar_min", min1, 0);
        chk("ar_running", running1, 0);
        chk("ar_ring", ring1, 0);
        chk("ar_done", done1, 0);
        cyc();
        chk("ar_done_hold", done1, 0);
        reset = 1'b0;
        cyc();
        chk("ar_idle_after", running1, 0);
        chk("ar_done_after", done1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
